// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON_PH  = 2'd1,
        OFF_PH = 2'd2,
        GAP    = 2'd3
    } ch_state_e;

    // Clock cycles per millisecond; never below one so the prescaler stays legal.
    function automatic int clk_per_ms(input int f_clk_hz);
        return (f_clk_hz / 1000 < 1) ? 1 : f_clk_hz / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_pattern_ch.sv
// One LED channel: configuration registers plus the OFF/ON/BLINK/BURST phase FSM.
// All state is reset synchronously; a write or a global restart reloads the pattern.
module led_pattern_ch
    import led_pattern_pkg::*;
#(
    parameter int MS_W    = 12,
    parameter int BURST_W = 4,
    parameter int GAP_MS  = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ms_tick,
    input  logic               wr_en,
    input  logic               restart,
    input  logic [1:0]         cfg_mode,
    input  logic [MS_W-1:0]    cfg_on_ms,
    input  logic [MS_W-1:0]    cfg_off_ms,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               led,
    output logic               cyc_start
);

    localparam int GAP_W = $clog2(GAP_MS + 1);
    localparam int CNT_W = max3(MS_W, BURST_W, GAP_W);
    localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);
    localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);

    mode_e              mode_q, mode_d;
    logic [MS_W-1:0]    on_q, on_d;
    logic [MS_W-1:0]    off_q, off_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic               led_q, led_d;
    logic               cyc_q, cyc_d;

    logic [CNT_W-1:0]   ms_nxt;
    logic [BURST_W-1:0] pulse_nxt;
    logic               eff_pattern;
    logic               eff_on;

    // Next-state logic: config latch, degenerate-pattern folding, phase sequencing.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        mode_d   = mode_q;
        on_d     = on_q;
        off_d    = off_q;
        burst_d  = burst_q;
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        pulse_d  = pulse_q;
        cyc_d    = 1'b0;

        ms_nxt    = ms_cnt_q + ONE_C;
        pulse_nxt = pulse_q + ONE_B;

        if (wr_en) begin
            mode_d  = mode_e'(cfg_mode);
            on_d    = cfg_on_ms;
            off_d   = cfg_off_ms;
            burst_d = cfg_burst;
        end

        // Degenerate settings collapse to OFF or steady ON, evaluated on the new config.
        eff_pattern = ((mode_d == MODE_BLINK) && (on_d != '0) && (off_d != '0)) ||
                      ((mode_d == MODE_BURST) && (on_d != '0) && (burst_d != '0));
        eff_on      = (mode_d == MODE_ON) ||
                      ((mode_d == MODE_BLINK) && (on_d != '0) && (off_d == '0));

        if (wr_en || restart) begin
            // A restart wins over a coincident tick; that tick is simply dropped.
            ms_cnt_d = '0;
            pulse_d  = '0;
            if (eff_pattern) begin
                state_d = ON_PH;
                cyc_d   = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (ms_tick) begin
            unique case (state_q)
                ON_PH: begin
                    if (ms_nxt == CNT_W'(on_q)) begin
                        ms_cnt_d = '0;
                        if (mode_q == MODE_BURST) begin
                            if (pulse_nxt == burst_q) begin
                                state_d = GAP;
                                pulse_d = '0;
                            end else begin
                                pulse_d = pulse_nxt;
                                // Zero off time merges consecutive pulses into one lit span.
                                state_d = (off_q == '0) ? ON_PH : OFF_PH;
                            end
                        end else begin
                            state_d = OFF_PH;
                        end
                    end else begin
                        ms_cnt_d = ms_nxt;
                    end
                end
                OFF_PH: begin
                    if (ms_nxt == CNT_W'(off_q)) begin
                        ms_cnt_d = '0;
                        state_d  = ON_PH;
                        // Inside a burst only the first pulse marks a new period.
                        cyc_d    = (mode_q == MODE_BLINK);
                    end else begin
                        ms_cnt_d = ms_nxt;
                    end
                end
                GAP: begin
                    if (ms_nxt == CNT_W'(GAP_MS)) begin
                        ms_cnt_d = '0;
                        state_d  = ON_PH;
                        cyc_d    = 1'b1;
                    end else begin
                        ms_cnt_d = ms_nxt;
                    end
                end
                default: ;
            endcase
        end

        led_d = (state_d == ON_PH) || eff_on;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: config registers are reset too, so a reset aborts the pattern completely.
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            on_q     <= '0;
            off_q    <= '0;
            burst_q  <= '0;
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            pulse_q  <= '0;
            led_q    <= 1'b0;
            cyc_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same old values.
            mode_q   <= mode_d;
            on_q     <= on_d;
            off_q    <= off_d;
            burst_q  <= burst_d;
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            pulse_q  <= pulse_d;
            led_q    <= led_d;
            cyc_q    <= cyc_d;
        end
    end

    assign led       = led_q;
    assign cyc_start = cyc_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared ms prescaler, config write decode,
// and N_CH pattern channels. Optional LED_PATTERN_SYNC_EN adds sync_req, a global
// restart that phase-aligns every patterned channel.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int F_CLK_HZ = 25_000_000,
    parameter int N_CH     = 9,
    parameter int MS_W     = 12,
    parameter int BURST_W  = 4,
    parameter int GAP_MS   = 1000
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_ch,
    input  logic [1:0]                                  cfg_mode,
    input  logic [MS_W-1:0]                             cfg_on_ms,
    input  logic [MS_W-1:0]                             cfg_off_ms,
    input  logic [BURST_W-1:0]                          cfg_burst,
`ifdef LED_PATTERN_SYNC_EN
    input  logic                                        sync_req,
`endif
    output logic [N_CH-1:0]                             led,
    output logic [N_CH-1:0]                             cyc_start,
    output logic                                        ms_tick
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CPM  = clk_per_ms(F_CLK_HZ);
    localparam int PS_W = (CPM > 1) ? $clog2(CPM) : 1;
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CPM - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_q, tick_d;
    logic            sync_int;

`ifdef LED_PATTERN_SYNC_EN
    assign sync_int = sync_req;
`else
    assign sync_int = 1'b0;
`endif

    // Millisecond prescaler; a sync clears it so the next full ms starts now.
    always_comb begin
        ps_d   = ps_q + PS_ONE;
        tick_d = 1'b0;
        if (sync_int) begin
            ps_d = '0;
        end else if (ps_q == PS_LAST) begin
            ps_d   = '0;
            tick_d = 1'b1;
        end
    end

    // Prescaler registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            tick_q <= tick_d;
        end
    end

    assign ms_tick = tick_q;

    // Channel array; an out-of-range cfg_ch matches no channel and is dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg_we && (cfg_ch == CH_W'(i));

        led_pattern_ch #(
            .MS_W    (MS_W),
            .BURST_W (BURST_W),
            .GAP_MS  (GAP_MS)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .ms_tick    (tick_q),
            .wr_en      (wr_en),
            .restart    (sync_int),
            .cfg_mode   (cfg_mode),
            .cfg_on_ms  (cfg_on_ms),
            .cfg_off_ms (cfg_off_ms),
            .cfg_burst  (cfg_burst),
            .led        (led[i]),
            .cyc_start  (cyc_start[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at 4 clk/ms, GAP_MS=5.
// Define LED_PATTERN_SYNC_EN to include the global-restart sequence.
module tb_led_pattern_gen;

    localparam int N_CH = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [11:0] cfg_on_ms = '0;
    logic [11:0] cfg_off_ms = '0;
    logic [3:0]  cfg_burst = '0;
`ifdef LED_PATTERN_SYNC_EN
    logic        sync_req = 1'b0;
`endif
    logic [8:0]  led;
    logic [8:0]  cyc_start;
    logic        ms_tick;

    led_pattern_gen #(
        .F_CLK_HZ (4000),
        .N_CH     (N_CH),
        .MS_W     (12),
        .BURST_W  (4),
        .GAP_MS   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_on_ms  (cfg_on_ms),
        .cfg_off_ms (cfg_off_ms),
        .cfg_burst  (cfg_burst),
`ifdef LED_PATTERN_SYNC_EN
        .sync_req   (sync_req),
`endif
        .led        (led),
        .cyc_start  (cyc_start),
        .ms_tick    (ms_tick)
    );

    always #5 clk = ~clk;

    // One segment: optional write on its first edge, then `cycles` edges of a
    // constant led value; exp_cyc is expected on the first edge only.
    typedef struct {
        logic        we;
        logic [3:0]  ch;
        logic [1:0]  mode;
        logic [11:0] on_ms;
        logic [11:0] off_ms;
        logic [3:0]  burst;
        int          align;
        int          cycles;
        logic [8:0]  exp_led;
        logic [8:0]  exp_cyc;
    } seg_t;

    int         n_checks = 0;
    int         n_err = 0;
    int         since_rst = 0;
    logic [8:0] last_led = '0;
    seg_t       segs[$];

    function automatic seg_t mk(input logic we, input int ch, input int mode,
                                input int on_ms, input int off_ms, input int burst,
                                input int align, input int cycles,
                                input logic [8:0] exp_led, input logic [8:0] exp_cyc);
        seg_t s;
        s.we      = we;
        s.ch      = 4'(ch);
        s.mode    = 2'(mode);
        s.on_ms   = 12'(on_ms);
        s.off_ms  = 12'(off_ms);
        s.burst   = 4'(burst);
        s.align   = align;
        s.cycles  = cycles;
        s.exp_led = exp_led;
        s.exp_cyc = exp_cyc;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d after reset): got %0h, expected %0h",
                     name, since_rst, act, exp);
        end
    endtask

    // Advance one clock edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) since_rst = 0;
        else        since_rst++;
`ifdef LED_PATTERN_SYNC_EN
        if (sync_req) since_rst = 0;
`endif
    endtask

    task automatic check_cycle(input string tag, input logic [8:0] exp_led,
                               input logic [8:0] exp_cyc);
        check({tag, ".led"}, 32'(led), 32'(exp_led));
        check({tag, ".cyc_start"}, 32'(cyc_start), 32'(exp_cyc));
        check({tag, ".ms_tick"}, 32'(ms_tick),
              32'((since_rst > 0) && (since_rst % 4 == 0)));
    endtask

    task automatic run_seg(input seg_t s, input int idx);
        string tag;
        tag = $sformatf("seg%0d", idx);
        if (s.align >= 0) begin
            while (((since_rst + 1) % 4) != s.align) begin
                step();
                check_cycle({tag, ".align"}, last_led, 9'h000);
            end
        end
        cfg_we     = s.we;
        cfg_ch     = s.ch;
        cfg_mode   = s.mode;
        cfg_on_ms  = s.on_ms;
        cfg_off_ms = s.off_ms;
        cfg_burst  = s.burst;
        step();
        cfg_we = 1'b0;
        check_cycle(tag, s.exp_led, s.exp_cyc);
        for (int k = 1; k < s.cycles; k++) begin
            step();
            check_cycle(tag, s.exp_led, 9'h000);
        end
        last_led = s.exp_led;
    endtask

    initial begin
        // BLINK ch0 on=2 off=3, written two edges before a tick-consuming edge.
        segs.push_back(mk(1, 0, 2, 2, 3, 0, 2, 7, 9'h001, 9'h001));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 12, 9'h000, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 8, 9'h001, 9'h001));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 12, 9'h000, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 8, 9'h001, 9'h001));
        segs.push_back(mk(1, 0, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
        // BURST ch8 on=1 off=1 burst=3, two full bursts.
        segs.push_back(mk(1, 8, 3, 1, 1, 3, 2, 3, 9'h100, 9'h100));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h100, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h100, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 20, 9'h000, 9'h000));
        for (int b = 0; b < 2; b++) begin
            segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h100, 9'h100));
            segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
            segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h100, 9'h000));
            segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
            segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 9'h100, 9'h000));
            segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 20, 9'h000, 9'h000));
        end
        segs.push_back(mk(1, 8, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
        // Edge configurations.
        segs.push_back(mk(1, 3, 2, 0, 3, 0, -1, 12, 9'h000, 9'h000));
        segs.push_back(mk(1, 3, 2, 2, 0, 0, -1, 12, 9'h008, 9'h000));
        segs.push_back(mk(1, 3, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
        segs.push_back(mk(1, 4, 3, 2, 1, 0, -1, 12, 9'h000, 9'h000));
        segs.push_back(mk(1, 9, 1, 2, 2, 1, -1, 12, 9'h000, 9'h000));
        segs.push_back(mk(1, 5, 1, 0, 0, 0, -1, 8, 9'h020, 9'h000));
        segs.push_back(mk(1, 5, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
        // BURST ch6 with off=0: two pulses merge into one 2 ms span.
        segs.push_back(mk(1, 6, 3, 1, 0, 2, 2, 7, 9'h040, 9'h040));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 20, 9'h000, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 8, 9'h040, 9'h040));
        segs.push_back(mk(1, 6, 0, 0, 0, 0, -1, 4, 9'h000, 9'h000));
        // Rewrite ch0 on the edge that carries the tick ending its ON phase.
        segs.push_back(mk(1, 0, 2, 2, 3, 0, 2, 7, 9'h001, 9'h001));
        segs.push_back(mk(1, 0, 2, 2, 3, 0, -1, 8, 9'h001, 9'h001));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 12, 9'h000, 9'h000));
        segs.push_back(mk(0, 0, 0, 0, 0, 0, -1, 8, 9'h001, 9'h001));

        // Reset held for three edges.
        for (int k = 0; k < 3; k++) begin
            step();
            check_cycle("reset", 9'h000, 9'h000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check_cycle("idle", 9'h000, 9'h000);
        end

        foreach (segs[i]) run_seg(segs[i], i);

        // ch0 ends its ON phase on this edge while ch8 starts a burst.
        cfg_we = 1'b1; cfg_ch = 4'd8; cfg_mode = 2'd3;
        cfg_on_ms = 12'd1; cfg_off_ms = 12'd1; cfg_burst = 4'd3;
        step();
        cfg_we = 1'b0;
        check_cycle("burst_start", 9'h100, 9'h100);
        step();
        check_cycle("burst_hold", 9'h100, 9'h000);
        rst_n = 1'b0;
        step();
        check_cycle("mid_reset", 9'h000, 9'h000);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check_cycle("post_reset", 9'h000, 9'h000);
        end

`ifdef LED_PATTERN_SYNC_EN
        cfg_we = 1'b1; cfg_ch = 4'd1; cfg_mode = 2'd2;
        cfg_on_ms = 12'd2; cfg_off_ms = 12'd2; cfg_burst = 4'd0;
        step();
        cfg_we = 1'b0;
        for (int k = 0; k < 4; k++) step();
        cfg_we = 1'b1; cfg_ch = 4'd2;
        step();
        cfg_we = 1'b0;
        for (int k = 0; k < 3; k++) step();
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        check_cycle("sync_rise", 9'h006, 9'h006);
        for (int k = 0; k < 8; k++) begin
            step();
            check_cycle("sync_on", 9'h006, 9'h000);
        end
        last_led = 9'h006;
        run_seg(mk(0, 0, 0, 0, 0, 0, -1, 8, 9'h000, 9'h000), 100);
        run_seg(mk(0, 0, 0, 0, 0, 0, -1, 8, 9'h006, 9'h006), 101);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
